// File: rtl/cache_pkg.sv
// Shared defaults and FSM state encoding for the cache refill controller.
package cache_pkg;

  localparam int unsigned DEF_NUMBER_OF_WAYS = 8;
  localparam int unsigned DEF_INDEX_BITS     = 6;
  localparam int unsigned DEF_TAG_BITS       = 20;
  localparam int unsigned DEF_LINE_WIDTH     = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WB,
    S_RD,
    S_RWAIT,
    S_FILL
  } state_t;

endpackage

// File: rtl/cache_refill_controller_if.sv
// Next-level memory bus: one request channel (read or writeback) plus read return.
interface cache_refill_controller_if
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned TAG_BITS   = DEF_TAG_BITS,
  parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH
);

  logic                           mem_req;
  logic                           mem_we;
  logic [TAG_BITS+INDEX_BITS-1:0] mem_addr;
  logic [LINE_WIDTH-1:0]          mem_wdata;
  logic                           mem_ready;
  logic                           mem_rvalid;
  logic [LINE_WIDTH-1:0]          mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lowest_one_hot_select.sv
// Reduces a possibly multi-hot way vector to its lowest set bit (zero stays zero).
module lowest_one_hot_select
  import cache_pkg::*;
#(
  parameter int unsigned NUMBER_OF_WAYS = DEF_NUMBER_OF_WAYS
) (
  input  logic [NUMBER_OF_WAYS-1:0] way_in,
  output logic [NUMBER_OF_WAYS-1:0] way_out
);

  logic found;

  always_comb begin
    way_out = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUMBER_OF_WAYS; i++) begin
      if (way_in[i] && !found) begin
        way_out[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_refill_controller.sv
// Miss handling: optional dirty-victim writeback, line read, then a one-cycle fill.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int unsigned NUMBER_OF_WAYS = DEF_NUMBER_OF_WAYS,
  parameter int unsigned INDEX_BITS     = DEF_INDEX_BITS,
  parameter int unsigned TAG_BITS       = DEF_TAG_BITS,
  parameter int unsigned LINE_WIDTH     = DEF_LINE_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      miss_req,
  input  logic [INDEX_BITS-1:0]     miss_index,
  input  logic [TAG_BITS-1:0]       miss_tag,
  output logic                      miss_ready,
  input  logic [NUMBER_OF_WAYS-1:0] selected_way,
  input  logic                      victim_valid,
  input  logic                      victim_dirty,
  input  logic [TAG_BITS-1:0]       victim_tag,
  input  logic [LINE_WIDTH-1:0]     victim_data,
  cache_refill_controller_if.master mem_bus,
  output logic                      fill_we,
  output logic [NUMBER_OF_WAYS-1:0] fill_way,
  output logic [INDEX_BITS-1:0]     fill_index,
  output logic [TAG_BITS-1:0]       fill_tag,
  output logic [LINE_WIDTH-1:0]     fill_data,
  output logic                      access_valid,
  output logic [NUMBER_OF_WAYS-1:0] current_access,
  output logic                      done,
  input  logic                      report
);

  state_t state_q, state_d;

  logic [INDEX_BITS-1:0]     idx_q;
  logic [TAG_BITS-1:0]       tag_q;
  logic [NUMBER_OF_WAYS-1:0] way_q;
  logic [TAG_BITS-1:0]       vtag_q;
  logic [LINE_WIDTH-1:0]     vdata_q;
  logic [LINE_WIDTH-1:0]     rdata_q;
  logic [NUMBER_OF_WAYS-1:0] way_sel;

  logic [31:0] cycle_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;

  logic accept;
  logic way_ok;
  logic go_wb;

  lowest_one_hot_select #(.NUMBER_OF_WAYS(NUMBER_OF_WAYS)) u_way_sel (
    .way_in  (selected_way),
    .way_out (way_sel)
  );

  assign accept = (state_q == S_IDLE) && miss_req;
  assign way_ok = (state_q == S_LATCH) && (way_sel != '0);
  assign go_wb  = way_ok && victim_valid && victim_dirty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (miss_req) state_d = S_LATCH;
      S_LATCH: if (way_sel != '0) state_d = (victim_valid && victim_dirty) ? S_WB : S_RD;
      S_WB:    if (mem_bus.mem_ready) state_d = S_RD;
      S_RD:    if (mem_bus.mem_ready) state_d = S_RWAIT;
      S_RWAIT: if (mem_bus.mem_rvalid) state_d = S_FILL;
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Victim fields are captured alongside the way so WB holds stable while the array moves on.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      vtag_q  <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= miss_index;
        tag_q <= miss_tag;
      end
      if (way_ok) begin
        way_q   <= way_sel;
        vtag_q  <= victim_tag;
        vdata_q <= victim_data;
      end
      if ((state_q == S_RWAIT) && mem_bus.mem_rvalid) rdata_q <= mem_bus.mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      miss_count  <= '0;
      wb_count    <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (accept) miss_count <= miss_count + 32'd1;
      if (go_wb)  wb_count   <= wb_count + 32'd1;
    end
  end

  // All outputs decode from state and latched fields only, never from memory inputs.
  always_comb begin
    miss_ready        = 1'b0;
    mem_bus.mem_req   = 1'b0;
    mem_bus.mem_we    = 1'b0;
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wdata = '0;
    fill_we           = 1'b0;
    fill_way          = '0;
    fill_index        = '0;
    fill_tag          = '0;
    fill_data         = '0;
    access_valid      = 1'b0;
    current_access    = '0;
    done              = 1'b0;
    unique case (state_q)
      S_IDLE: miss_ready = 1'b1;
      S_WB: begin
        mem_bus.mem_req   = 1'b1;
        mem_bus.mem_we    = 1'b1;
        mem_bus.mem_addr  = {vtag_q, idx_q};
        mem_bus.mem_wdata = vdata_q;
      end
      S_RD: begin
        mem_bus.mem_req  = 1'b1;
        mem_bus.mem_addr = {tag_q, idx_q};
      end
      S_FILL: begin
        fill_we        = 1'b1;
        fill_way       = way_q;
        fill_index     = idx_q;
        fill_tag       = tag_q;
        fill_data      = rdata_q;
        access_valid   = 1'b1;
        current_access = way_q;
        done           = 1'b1;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report)
      $display("cache_refill_controller: cycles=%0d misses=%0d writebacks=%0d state=%s",
               cycle_count, miss_count, wb_count, state_q.name());
  end
`endif

endmodule

// File: doc/cache_refill_controller.md
CACHE_REFILL_CONTROLLER -- requirements
Module: cache_refill_controller

Interface
REQ-001 Parameter NUMBER_OF_WAYS, default 8: associativity; width of every one-hot way vector.
REQ-002 Parameter INDEX_BITS, default 6: set index width.
REQ-003 Parameter TAG_BITS, default 20: tag width.
REQ-004 Parameter LINE_WIDTH, default 128: cache line width, transferred as one beat.
REQ-005 Port clock, in, 1: sole clock, all state on rising edge.
REQ-006 Port reset, in, 1: asynchronous, active-low reset.
REQ-007 Ports miss_req (in, 1), miss_index (in, INDEX_BITS) and miss_tag (in, TAG_BITS): miss request from the tag-compare stage.
REQ-008 Port miss_ready, out, 1: high only in IDLE; a miss is accepted when miss_req && miss_ready.
REQ-009 Port selected_way, in, NUMBER_OF_WAYS: one-hot victim choice from the replacement controller.
REQ-010 Ports victim_valid, victim_dirty (in, 1), victim_tag (in, TAG_BITS) and victim_data (in, LINE_WIDTH): array contents of the selected way at the latched index.
REQ-011 Ports mem_req, mem_we (out, 1), mem_addr (out, TAG_BITS+INDEX_BITS, {tag,index}) and mem_wdata (out, LINE_WIDTH): request to next level.
REQ-012 Ports mem_ready, mem_rvalid (in, 1) and mem_rdata (in, LINE_WIDTH): next-level request accept and read return.
REQ-013 Ports fill_we (out, 1), fill_way (out, NUMBER_OF_WAYS), fill_index, fill_tag and fill_data: line write into the arrays; the written line is valid and clean.
REQ-014 Ports access_valid (out, 1) and current_access (out, NUMBER_OF_WAYS): one-cycle recency update to the replacement controller.
REQ-015 Ports done (out, 1): one-cycle completion pulse; report (in, 1): print performance counters.

Function
REQ-016 FSM states are IDLE, LATCH, WB, RD, RWAIT and FILL.
REQ-017 IDLE: on an accepted miss, latch miss_index and miss_tag, then go to LATCH.
REQ-018 LATCH: latch selected_way, reduced to its lowest set bit if multi-hot, together with the victim inputs; if selected_way is zero, stay in LATCH.
REQ-019 LATCH exit: go to WB if victim_valid && victim_dirty, otherwise go to RD.
REQ-020 WB: mem_req=1, mem_we=1, mem_addr={victim_tag,index}, mem_wdata=victim_data; hold all of these stable until mem_ready is sampled high, then go to RD.
REQ-021 RD: mem_req=1, mem_we=0, mem_addr={miss_tag,index}; hold stable until mem_ready is sampled high, then go to RWAIT.
REQ-022 RWAIT: on mem_rvalid, latch mem_rdata and go to FILL; a mem_rvalid in any other state is ignored.
REQ-023 FILL lasts exactly one cycle and asserts fill_we=1, access_valid=1 and done=1, with fill_way=current_access=latched way; then go to IDLE.
REQ-024 mem_ready and mem_rvalid may be asserted in the same cycle as entry to a state; the transition then occurs at the next edge.
REQ-025 Clean-miss latency, with mem_ready high and mem_rvalid one cycle after acceptance: accept edge N, FILL during cycle N+3.
REQ-026 Outputs are registered or decoded from state only; no combinational path from memory inputs to mem_req.
REQ-027 Performance counters: cycles, misses and writebacks, each 32 bits, wrapping at overflow.
REQ-028 When report is high, display the three counters and the current state.

Reset
REQ-029 Assertion of reset immediately forces IDLE: mem_req, mem_we, fill_we, access_valid and done are 0; all way vectors and data outputs are 0; miss_ready=1.
REQ-030 Reset asserted mid-operation abandons the transaction with no fill; the first request after reset release is accepted normally.
REQ-031 Performance counters clear to 0 on reset.

Structure
REQ-032 State encodings and default parameter values live in shared package cache_pkg.
REQ-033 Lowest-set-bit way selection is sub-module lowest_one_hot_select (NUMBER_OF_WAYS parameter, combinational).

Verification
REQ-034 Clean miss (victim_valid=0), index=5, tag=0x1234, mem_ready=1, rdata=A returning after 1 cycle -> no WB; fill_we at N+3 with fill_index=5, fill_tag=0x1234, fill_data=A; done pulses once.
REQ-035 Dirty victim, tag=0xABC, selected_way=8'b00100000 -> WB with mem_addr={0xABC,idx}, mem_we=1, then RD; fill_way=current_access=00100000; writebacks=1.
REQ-036 mem_ready held low 4 cycles in WB -> mem_req, mem_addr and mem_wdata stable all 4 cycles; miss_ready=0 throughout.
REQ-037 selected_way=0 for 3 cycles, then 8'b01010000 -> LATCH held 3 cycles; chosen way is 00010000.
REQ-038 Reset pulled low in RWAIT, mem_rvalid then arrives -> no fill_we and no done; miss_ready=1; the next miss completes normally.
